// File: rtl/traffic_light_timer.sv
// traffic_light_timer: three-phase traffic light sequencer (RED -> GREEN ->
// YELLOW -> RED). The phase counter is decremented by the external shared
// 16-bit adder/subtractor, and this block checks that adder's results.
// Optional pedestrian-request support is compiled in with `TLT_PED_REQ_EN.
module traffic_light_timer #(
  parameter int unsigned GREEN_T  = 30,
  parameter int unsigned YELLOW_T = 5,
  parameter int unsigned RED_T    = 25,
  parameter int unsigned PED_CUT  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        ped_req,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_ctrl,
  input  logic [15:0] add_sum,
  input  logic        add_cout,
  input  logic        add_o,
  output logic        red,
  output logic        yellow,
  output logic        green,
  output logic        walk,
  output logic        err
);

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } state_t;

  // Counter reload values: a phase of N ticks counts N-1 down to 0.
  localparam logic [15:0] GREEN_LD  = 16'(GREEN_T - 1);
  localparam logic [15:0] YELLOW_LD = 16'(YELLOW_T - 1);
  localparam logic [15:0] RED_LD    = 16'(RED_T - 1);
  localparam logic [15:0] PED_LD    = 16'(PED_CUT);

  state_t      st;
  logic [15:0] cnt;
  logic        cnt_zero;
  logic [15:0] cnt_dec;
  logic        sum_bad;
  logic        cut;
  logic        enter_red;
  logic        leave_red;

  // The external adder always computes cnt - 1; no handshake is needed.
  assign add_a    = cnt;
  assign add_b    = 16'h0001;
  assign add_ctrl = 1'b1;

  assign cnt_zero  = (cnt == 16'd0);
  assign cnt_dec   = cnt - 16'd1;
  assign sum_bad   = !add_cout || add_o || (add_sum != cnt_dec);
  assign enter_red = tick && cnt_zero && (st == YELLOW);
  assign leave_red = tick && cnt_zero && (st == RED);

`ifdef TLT_PED_REQ_EN
  logic ped_pend;
  logic pend_eff;

  // A request in the current cycle counts immediately, so a press on the
  // first GREEN tick already shortens that tick's reload.
  assign pend_eff = ped_pend | ped_req;
  assign cut      = (st == GREEN) && pend_eff && (cnt > PED_LD);

  // Latch pedestrian requests and drive the walk lamp for the RED phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      ped_pend <= 1'b0;
      walk     <= 1'b0;
    end else if (enter_red) begin
      walk     <= pend_eff;
      ped_pend <= ped_req;
    end else begin
      ped_pend <= ped_pend | ped_req;
      if (leave_red) begin
        walk <= 1'b0;
      end
    end
  end
`else
  logic unused_ped;

  assign unused_ped = ped_req;
  assign cut        = 1'b0;
  assign walk       = 1'b0;
`endif

  // Phase sequencer: state, counter and registered one-hot lamps.
  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= RED;
      cnt    <= RED_LD;
      red    <= 1'b1;
      yellow <= 1'b0;
      green  <= 1'b0;
    end else if (tick) begin
      if (cnt_zero) begin
        case (st)
          RED: begin
            st     <= GREEN;
            cnt    <= GREEN_LD;
            red    <= 1'b0;
            yellow <= 1'b0;
            green  <= 1'b1;
          end
          GREEN: begin
            st     <= YELLOW;
            cnt    <= YELLOW_LD;
            red    <= 1'b0;
            yellow <= 1'b1;
            green  <= 1'b0;
          end
          default: begin
            st     <= RED;
            cnt    <= RED_LD;
            red    <= 1'b1;
            yellow <= 1'b0;
            green  <= 1'b0;
          end
        endcase
      end else if (cut) begin
        cnt <= PED_LD;
      end else begin
        cnt <= add_sum;
      end
    end
  end

  // Sticky adder-consistency error; skipped on zero and shortening ticks
  // because the adder result is not consumed then.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (tick && !cnt_zero && !cut && sum_bad) begin
      err <= 1'b1;
    end
  end

endmodule
